// File: rtl/fetch_align_pkg.sv
// Shared types and constants for the RV32 fetch aligner: RVC quadrant encodings
// and the aligned-instruction bundle handed to decode.
package fetch_align_pkg;

    localparam int half_w     = 16;
    localparam int quadrant_w = 2;

    localparam logic [quadrant_w-1:0] opcode_c0 = 2'b00;
    localparam logic [quadrant_w-1:0] opcode_c1 = 2'b01;
    localparam logic [quadrant_w-1:0] opcode_c2 = 2'b10;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        valid;
    } fetch_out_t;

    // Any quadrant other than 2'b11 marks a 16-bit compressed encoding.
    function automatic logic is_compressed(input logic [half_w-1:0] half);
        return (half[quadrant_w-1:0] == opcode_c0) ||
               (half[quadrant_w-1:0] == opcode_c1) ||
               (half[quadrant_w-1:0] == opcode_c2);
    endfunction

endpackage

// File: rtl/fetch_align_if.sv
// Fetch aligner bus bundle: instruction-memory request/response, redirect,
// and the aligned instruction handshake towards decode.
interface fetch_align_if;

    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_comp;
    logic        instr_ready;

    modport master (
        output imem_valid, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  flush, flush_pc,
        output instr_valid, instr, instr_pc, instr_comp,
        input  instr_ready
    );

    modport slave (
        input  imem_valid, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output flush, flush_pc,
        input  instr_valid, instr, instr_pc, instr_comp,
        output instr_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Halfword circular FIFO for the fetch aligner: up to two pushes and two pops
// per cycle, synchronous clear, and a two-entry peek at the head.
module fetch_buffer
    import fetch_align_pkg::*;
#(
    parameter int depth = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [1:0]              push_n,
    input  logic [half_w-1:0]       push_lo,
    input  logic [half_w-1:0]       push_hi,
    input  logic [1:0]              pop_n,
    output logic [$clog2(depth):0]  count,
    output logic [half_w-1:0]       head0,
    output logic [half_w-1:0]       head1
);

    localparam int aw = $clog2(depth);

    logic [half_w-1:0] mem [depth];
    logic [aw-1:0]     wr_ptr;
    logic [aw-1:0]     rd_ptr;
    logic [aw:0]       cnt_q;

    // Storage needs no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clock) begin
        if (push_n != 2'd0) begin
            mem[wr_ptr] <= push_lo;
        end
        if (push_n == 2'd2) begin
            mem[wr_ptr + aw'(1)] <= push_hi;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            wr_ptr <= wr_ptr + aw'(push_n);
            rd_ptr <= rd_ptr + aw'(pop_n);
            cnt_q  <= cnt_q + (aw+1)'(push_n) - (aw+1)'(pop_n);
        end
    end

    assign count = cnt_q;
    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + aw'(1)];

endmodule

// File: rtl/fetch_align.sv
// Instruction fetch aligner: issues word fetches, buffers halfwords and hands
// decode one aligned 16- or 32-bit instruction per handshake, with redirect flush.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int          depth    = 8,
    parameter logic [31:0] reset_pc = 32'h0
) (
    input  logic          clock,
    input  logic          reset,
    fetch_align_if.master bus
);

    localparam int cw = $clog2(depth) + 1;

    logic [31:0]       fpc;
    logic [31:0]       hpc;
    logic [1:0]        out_cnt;
    logic [1:0]        dsc;
    logic              skip;

    logic [cw-1:0]     cnt;
    logic [half_w-1:0] head0;
    logic [half_w-1:0] head1;
    logic [1:0]        push_n;
    logic [1:0]        pop_n;
    logic [half_w-1:0] push_lo;
    logic [half_w-1:0] push_hi;
    logic [cw:0]       free_slots;
    logic [cw:0]       need_slots;
    logic              issue_ok;
    logic              accept;
    logic              consume;
    logic              head_comp;
    fetch_out_t        fout;

    fetch_buffer #(.depth(depth)) u_buffer (
        .clock   (clock),
        .reset   (reset),
        .clear   (bus.flush),
        .push_n  (push_n),
        .push_lo (push_lo),
        .push_hi (push_hi),
        .pop_n   (pop_n),
        .count   (cnt),
        .head0   (head0),
        .head1   (head1)
    );

    // Only request when every outstanding response, plus this one, is guaranteed room.
    assign free_slots = (cw+1)'(depth) - {1'b0, cnt};
    assign need_slots = (cw+1)'({out_cnt, 1'b0} + 3'd2);
    assign issue_ok   = (out_cnt < 2'd2) && (free_slots >= need_slots) && !bus.flush;
    assign accept     = issue_ok && bus.imem_ready;

    assign bus.imem_valid = reset && issue_ok;
    assign bus.imem_addr  = fpc;

    assign head_comp = is_compressed(head0);
    assign consume   = fout.valid && bus.instr_ready && !bus.flush;
    assign pop_n     = consume ? (head_comp ? 2'd1 : 2'd2) : 2'd0;

    // A pending skip means the redirect landed mid-word, so its low half is stale.
    always_comb begin
        push_n  = 2'd0;
        push_lo = bus.imem_rdata[15:0];
        push_hi = bus.imem_rdata[31:16];
        if (bus.imem_rvalid && !bus.flush && dsc == 2'd0) begin
            if (skip) begin
                push_n  = 2'd1;
                push_lo = bus.imem_rdata[31:16];
            end else begin
                push_n  = 2'd2;
            end
        end
    end

    always_comb begin
        fout       = '0;
        fout.pc    = hpc;
        fout.valid = (cnt != '0 && head_comp) || (cnt >= cw'(2) && !head_comp);
        if (fout.valid) begin
            fout.comp  = head_comp;
            fout.instr = head_comp ? {16'h0, head0} : {head1, head0};
        end
    end

    assign bus.instr_valid = fout.valid;
    assign bus.instr       = fout.instr;
    assign bus.instr_pc    = fout.pc;
    assign bus.instr_comp  = fout.comp;

    // A response landing in the flush cycle is dropped here, so it is not left in dsc.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fpc     <= reset_pc & ~32'h3;
            hpc     <= reset_pc & ~32'h1;
            out_cnt <= 2'd0;
            dsc     <= 2'd0;
            skip    <= reset_pc[1];
        end else if (bus.flush) begin
            fpc     <= bus.flush_pc & ~32'h3;
            hpc     <= bus.flush_pc & ~32'h1;
            skip    <= bus.flush_pc[1];
            out_cnt <= out_cnt - {1'b0, bus.imem_rvalid};
            dsc     <= out_cnt - {1'b0, bus.imem_rvalid};
        end else begin
            if (accept) begin
                fpc <= fpc + 32'd4;
            end
            hpc     <= hpc + {29'd0, pop_n, 1'b0};
            out_cnt <= out_cnt + {1'b0, accept} - {1'b0, bus.imem_rvalid};
            if (bus.imem_rvalid && dsc != 2'd0) begin
                dsc <= dsc - 2'd1;
            end
            if (bus.imem_rvalid && dsc == 2'd0) begin
                skip <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_align.md
# fetch_align

Instruction fetch aligner that sits between instruction memory and the decode/RVC-expand stage of the RV32 core. It issues word-aligned fetch requests, holds the returned data as a halfword FIFO, and presents one aligned instruction per handshake to decode. The instruction is either 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. It also handles redirect flushes, discarding stale in-flight responses.

## Interface
Parameters:
- depth, 8: halfword FIFO entries. Must be a power of two and at least 4.
- reset_pc, 32'h0: fetch start address after reset. Must be halfword-aligned.

Ports:
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- imem_valid, out, 1: fetch request valid.
- imem_addr, out, 32: request address, always word-aligned (bits [1:0] = 0).
- imem_ready, in, 1: request accepted when imem_valid && imem_ready.
- imem_rvalid, in, 1: response data valid. Responses return in request order, at least 1 cycle after acceptance.
- imem_rdata, in, 32: response word.
- flush, in, 1: redirect request.
- flush_pc, in, 32: redirect target. Bit 0 is ignored.
- instr_valid, out, 1: aligned instruction available.
- instr, out, 32: instruction. Compressed instructions are zero-extended, with the halfword in [15:0].
- instr_pc, out, 32: address of the instruction.
- instr_comp, out, 1: 1 when instr[1:0] != 2'b11.
- instr_ready, in, 1: decode consumes when instr_valid && instr_ready.

## Operation
- State:
  - fetch pointer fpc, word-aligned
  - head pc hpc
  - FIFO count cnt (0..depth)
  - outstanding counter out_cnt (0..2)
  - discard counter dsc (0..2)
  - skip flag skip
- Request issue: imem_valid = (out_cnt < 2) && (depth − cnt ≥ 2·(out_cnt+1)) && !flush.
  - imem_addr = fpc.
  - On acceptance: fpc += 4, out_cnt += 1.
- Response, when dsc == 0: push imem_rdata[15:0], then [31:16].
  - If skip is set, drop the low halfword, push only [31:16], and clear skip.
  - out_cnt −= 1.
- Response, when dsc > 0: drop the data; dsc −= 1 and out_cnt −= 1.
- Output validity:
  - instr_valid = (cnt ≥ 1 && head[1:0] != 2'b11) || (cnt ≥ 2 && head[1:0] == 2'b11).
  - A 32-bit instruction whose upper half has not yet arrived holds instr_valid low.
- Output data:
  - 32-bit: instr = {fifo[head+1], fifo[head]}.
  - Compressed: instr = {16'h0, fifo[head]}.
  - instr_pc = hpc.
- Consume: pop 1 halfword (compressed) or 2 (32-bit); hpc += 2 or 4.
- Push and pop may occur in the same cycle. cnt updates by push count minus pop count and never exceeds depth; the issue rule guarantees space.
- Flush (highest priority):
  - cnt ← 0
  - fpc ← {flush_pc[31:2], 2'b00}
  - hpc ← {flush_pc[31:1], 1'b0}
  - skip ← flush_pc[1]
  - dsc ← out_cnt, counting a response arriving in the flush cycle as still in flight; that response is discarded and not counted twice
  - No request is issued and no consume occurs in the flush cycle; instr_ready is ignored.
- Pointers wrap modulo depth. The only addressing arithmetic is 32-bit unsigned wrap on fpc and hpc.

## Timing
- Reset values:
  - imem_valid = 0 while reset is asserted; 1 in the first cycle after release.
  - imem_addr = reset_pc & ~3.
  - instr_valid = 0, instr = 0, instr_pc = reset_pc, instr_comp = 0.
  - cnt = out_cnt = dsc = 0; skip = reset_pc[1].
- Latency: a response in cycle t makes data visible on instr* in cycle t+1. Output is combinational from FIFO state.
- The first instruction after a flush is visible no earlier than 2 cycles after the first post-flush request is accepted.
- instr and instr_pc stay stable while instr_valid && !instr_ready, unless flush is asserted.
- Reset asserted mid-operation clears all state immediately; late responses after reset release are not expected.

## Structure
- Shared package additions:
  - fetch output struct typedef (instr, pc, comp, valid)
  - opcode field width constants
  - the existing opcode_c0/c1/c2 values, used to detect compressed encodings
- One sub-module: fetch_buffer, a halfword circular FIFO with 0/1/2 push, 0/1/2 pop, clear, count, and 2-entry head peek.
- fetch_align holds the request/discard control and the output handshake.

## Test plan
- Reset release with reset_pc=0: first request has imem_addr=0. Response 32'h00A00093 → instr=32'h00A00093, instr_pc=0, instr_comp=0.
- Response 32'h45814501 at addr 0 → two compressed instructions in consecutive cycles: 32'h00004501 at pc 0, then 32'h00004581 at pc 2.
- Straddle: word 0 = 32'h00934501, word 4 = 32'h????00A0 → compressed 4501 at pc 0, then 32'h00A00093 at pc 2. Valid is held low until the second word arrives.
- Flush to 32'h102 with 2 requests outstanding: both old responses are dropped, the next request is at addr 32'h100, the low halfword is skipped, and the first instr_pc = 32'h102.
- Backpressure with instr_ready=0: FIFO fills to depth, imem_valid drops, and instr stays constant. Releasing ready drains in order with no halfword lost or duplicated.
- Flush in the same cycle as imem_rvalid and instr_ready: no consume occurs, that response is discarded, and dsc accounts for the remaining outstanding request.
